regfile_mux_rw: RTL and testbench

- Parametrised CPU register file: NUM_REGS x WIDTH storage, two combinational read ports, one synchronous write port.
- Next-generation replacement for the fixed 32x32 read-select mux in the CPU datapath.
- Adds optional write-to-read bypass and a hardwired-zero register 0.
- Adds a debug dump engine that streams every register out, one per cycle, over a valid/ready handshake.

---
 rtl/regfile_mux_rw.sv | 114 +++++++++++
 tb/tb_regfile_mux_rw.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mux_rw.sv
// Parametrised register file with two combinational read ports, one synchronous write port,
// an optional write-to-read bypass, an optional hardwired zero register and a dump engine.
module regfile_mux_rw #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_R0  = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              We,
    input  logic [ADDR_W-1:0] Wa,
    input  logic [WIDTH-1:0]  Wdata,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [WIDTH-1:0]  Qa,
    output logic [WIDTH-1:0]  Qb,
    input  logic              Dump_start,
    output logic              Dump_busy,
    output logic              Dump_valid,
    input  logic              Dump_ready,
    output logic [ADDR_W-1:0] Dump_addr,
    output logic [WIDTH-1:0]  Dump_data,
    output logic              Dump_last
);

    typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-1:0]  regs_d [NUM_REGS];
    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              dump_valid;
    logic              dump_last;

    function automatic logic [WIDTH-1:0] port_val(input logic [ADDR_W-1:0] addr,
                                                  input logic [WIDTH-1:0]  stored,
                                                  input logic              we,
                                                  input logic [ADDR_W-1:0] wa,
                                                  input logic [WIDTH-1:0]  wdata);
        // The zero register wins over bypass.
        if (ZERO_R0 && addr == '0) return '0;
        if (BYPASS && we && addr == wa) return wdata;
        return stored;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (We && !(ZERO_R0 && Wa == '0)) begin
            regs_d[Wa] = Wdata;
        end
    end

    always_comb begin
        Qa = port_val(Ra, regs_q[Ra], We, Wa, Wdata);
        Qb = port_val(Rb, regs_q[Rb], We, Wa, Wdata);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (Dump_start) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (Dump_ready) begin
                    if (idx_q == LastIdx) begin
                        // Leave SEND before the index can wrap.
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dump_valid = (state_q == StSend);
        dump_last  = dump_valid && (idx_q == LastIdx);
        Dump_busy  = (state_q != StIdle);
        Dump_valid = dump_valid;
        Dump_last  = dump_last;
        Dump_addr  = idx_q;
        Dump_data  = '0;
        // Third read path, independent of the Qa/Qb muxes and without bypass.
        if (dump_valid && !(ZERO_R0 && idx_q == '0)) begin
            Dump_data = regs_q[idx_q];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            regs_q  <= '{default: '0};
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_mux_rw.sv
// Directed self-checking bench for regfile_mux_rw; a second instance with BYPASS=0 shares
// the write/read inputs so both bypass settings are compared against the same stimulus.
module tb_regfile_mux_rw;

    logic        Clk = 1'b0;
    logic        Clrn, We, Dump_start, Dump_ready;
    logic [4:0]  Wa, Ra, Rb;
    logic [31:0] Wdata;
    logic [31:0] Qa, Qb, Dump_data;
    logic        Dump_busy, Dump_valid, Dump_last;
    logic [4:0]  Dump_addr;
    logic [31:0] nb_qa, nb_qb, nb_dump_data;
    logic        nb_dump_busy, nb_dump_valid, nb_dump_last;
    logic [4:0]  nb_dump_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_reg [32];

    always #5 Clk = ~Clk;

    regfile_mux_rw dut (
        .Clk(Clk), .Clrn(Clrn), .We(We), .Wa(Wa), .Wdata(Wdata), .Ra(Ra), .Rb(Rb),
        .Qa(Qa), .Qb(Qb), .Dump_start(Dump_start), .Dump_busy(Dump_busy),
        .Dump_valid(Dump_valid), .Dump_ready(Dump_ready), .Dump_addr(Dump_addr),
        .Dump_data(Dump_data), .Dump_last(Dump_last)
    );

    regfile_mux_rw #(.BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .Clrn(Clrn), .We(We), .Wa(Wa), .Wdata(Wdata), .Ra(Ra), .Rb(Rb),
        .Qa(nb_qa), .Qb(nb_qb), .Dump_start(1'b0), .Dump_busy(nb_dump_busy),
        .Dump_valid(nb_dump_valid), .Dump_ready(1'b0), .Dump_addr(nb_dump_addr),
        .Dump_data(nb_dump_data), .Dump_last(nb_dump_last)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Clrn = 1'b0; We = 1'b0; Wa = '0; Wdata = '0; Ra = '0; Rb = '0;
        Dump_start = 1'b0; Dump_ready = 1'b0;
        step();
        step();
        Clrn = 1'b1;
        #1;
        checks++;
        if ({Dump_busy, Dump_valid, Dump_last} !== 3'b000 || Dump_addr !== 5'd0
            || Dump_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_dump: busy/valid/last=%b%b%b addr=%0d data=%h, required 000 0 0",
                     Dump_busy, Dump_valid, Dump_last, Dump_addr, Dump_data);
        end
        for (int a = 0; a < 32; a++) begin
            Ra = 5'(a); Rb = 5'(31 - a);
            #1;
            checks++;
            if (Qa !== 32'd0 || Qb !== 32'd0) begin
                errors++;
                $display("FAIL reset_read a=%0d: Qa=%h Qb=%h, required 0 0", a, Qa, Qb);
            end
        end
        for (int k = 0; k < 32; k++) exp_reg[k] = 32'd0;
    endtask

    task automatic test_write_read();
        for (int k = 1; k < 32; k++) begin
            We = 1'b1; Wa = 5'(k); Wdata = 32'(k) * 32'h0101_0101;
            exp_reg[k] = Wdata;
            step();
        end
        We = 1'b0;
        Ra = 5'd5; Rb = 5'd31;
        #1;
        checks++;
        if (Qa !== 32'h0505_0505 || Qb !== 32'h1F1F_1F1F) begin
            errors++;
            $display("FAIL write_read: Qa=%h Qb=%h, required 05050505 1f1f1f1f", Qa, Qb);
        end
        checks++;
        if (nb_qa !== 32'h0505_0505 || nb_qb !== 32'h1F1F_1F1F) begin
            errors++;
            $display("FAIL write_read_nb: Qa=%h Qb=%h, required 05050505 1f1f1f1f",
                     nb_qa, nb_qb);
        end
        Ra = 5'd12; Rb = 5'd12;
        #1;
        checks++;
        if (Qa !== 32'h0C0C_0C0C || Qb !== 32'h0C0C_0C0C) begin
            errors++;
            $display("FAIL same_addr: Qa=%h Qb=%h, required 0c0c0c0c both", Qa, Qb);
        end
    endtask

    task automatic test_r0();
        We = 1'b1; Wa = 5'd0; Wdata = 32'hDEAD_BEEF; Ra = 5'd0; Rb = 5'd0;
        #1;
        checks++;
        if (Qa !== 32'd0 || Qb !== 32'd0) begin
            errors++;
            $display("FAIL r0_same_cycle: Qa=%h Qb=%h, required 0 0", Qa, Qb);
        end
        step();
        We = 1'b0;
        #1;
        checks++;
        if (Qa !== 32'd0 || nb_qa !== 32'd0) begin
            errors++;
            $display("FAIL r0_after: Qa=%h nb_Qa=%h, required 0 0", Qa, nb_qa);
        end
        step();
        checks++;
        if (Qb !== 32'd0) begin
            errors++;
            $display("FAIL r0_later: Qb=%h, required 0", Qb);
        end
    endtask

    task automatic test_bypass();
        We = 1'b1; Wa = 5'd7; Wdata = 32'h11;
        step();
        Wdata = 32'h22; Ra = 5'd7; Rb = 5'd7;
        #1;
        checks++;
        if (Qa !== 32'h22 || Qb !== 32'h22) begin
            errors++;
            $display("FAIL bypass_on: Qa=%h Qb=%h, required 22 22", Qa, Qb);
        end
        checks++;
        if (nb_qa !== 32'h11 || nb_qb !== 32'h11) begin
            errors++;
            $display("FAIL bypass_off_before: Qa=%h Qb=%h, required 11 11", nb_qa, nb_qb);
        end
        step();
        We = 1'b0;
        #1;
        checks++;
        if (nb_qa !== 32'h22 || Qa !== 32'h22) begin
            errors++;
            $display("FAIL bypass_after: nb_Qa=%h Qa=%h, required 22 22", nb_qa, Qa);
        end
        exp_reg[7] = 32'h22;
    endtask

    task automatic test_dump_backpressure();
        logic [3:0] pat;
        int nexp;
        int cyc;
        pat = 4'b1101;  // bit i drives ready in cycle i%4: 1,0,1,1
        nexp = 0;
        cyc = 0;
        Dump_start = 1'b1;
        step();
        Dump_start = 1'b0;
        while (nexp < 32 && cyc < 200) begin
            Dump_ready = pat[cyc % 4];
            #1;
            checks++;
            if (Dump_valid !== 1'b1 || Dump_busy !== 1'b1 || Dump_addr !== 5'(nexp)
                || Dump_data !== exp_reg[nexp] || Dump_last !== (nexp == 31)) begin
                errors++;
                $display("FAIL dump_beat %0d: v=%b b=%b addr=%0d data=%h last=%b, required v=1 b=1 addr=%0d data=%h last=%b",
                         nexp, Dump_valid, Dump_busy, Dump_addr, Dump_data, Dump_last,
                         nexp, exp_reg[nexp], (nexp == 31));
            end
            if (Dump_ready) nexp++;
            cyc++;
            step();
        end
        checks++;
        if (nexp != 32) begin
            errors++;
            $display("FAIL dump_timeout: beats=%0d, required 32", nexp);
        end
        Dump_ready = 1'b0;
        Dump_start = 1'b1;  // must be ignored in DONE
        #1;
        checks++;
        if (Dump_busy !== 1'b1 || Dump_valid !== 1'b0 || Dump_last !== 1'b0) begin
            errors++;
            $display("FAIL dump_done: busy=%b valid=%b last=%b, required 1 0 0",
                     Dump_busy, Dump_valid, Dump_last);
        end
        step();
        Dump_start = 1'b0;
        #1;
        checks++;
        if (Dump_busy !== 1'b0 || Dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_idle: busy=%b valid=%b, required 0 0", Dump_busy, Dump_valid);
        end
        step();
        checks++;
        if (Dump_busy !== 1'b0 || Dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_start_in_done: busy=%b valid=%b, required 0 0",
                     Dump_busy, Dump_valid);
        end
    endtask

    task automatic test_reset_mid_dump();
        int guard;
        guard = 0;
        Dump_ready = 1'b1;
        Dump_start = 1'b1;
        step();
        Dump_start = 1'b0;
        while (Dump_addr != 5'd10 && guard < 50) begin
            step();
            guard++;
        end
        checks++;
        if (Dump_addr !== 5'd10 || Dump_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_dump_reach: addr=%0d valid=%b, required 10 1", Dump_addr, Dump_valid);
        end
        Clrn = 1'b0;
        step();
        Clrn = 1'b1;
        #1;
        checks++;
        if (Dump_busy !== 1'b0 || Dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_dump_abort: busy=%b valid=%b, required 0 0", Dump_busy, Dump_valid);
        end
        for (int a = 0; a < 32; a++) begin
            Ra = 5'(a); Rb = 5'(a);
            #1;
            checks++;
            if (Qa !== 32'd0 || nb_qb !== 32'd0) begin
                errors++;
                $display("FAIL mid_dump_clear a=%0d: Qa=%h nb_Qb=%h, required 0 0", a, Qa, nb_qb);
            end
        end
        step();
        checks++;
        if (Dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_dump_no_beats: valid=%b, required 0", Dump_valid);
        end
        Dump_start = 1'b1;
        step();
        Dump_start = 1'b0;
        checks++;
        if (Dump_valid !== 1'b1 || Dump_addr !== 5'd0 || Dump_data !== 32'd0) begin
            errors++;
            $display("FAIL restart: valid=%b addr=%0d data=%h, required 1 0 0",
                     Dump_valid, Dump_addr, Dump_data);
        end
        step();
        checks++;
        if (Dump_addr !== 5'd1 || Dump_data !== 32'd0) begin
            errors++;
            $display("FAIL restart_next: addr=%0d data=%h, required 1 0", Dump_addr, Dump_data);
        end
        Dump_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_dump_backpressure();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
